// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the FFT output-side blocks.
//
//   state_t        : streamer FSM encodings (ST_IDLE, ST_STREAM)
//   FFT_N_DEFAULT  : default transform size used across the FFT blocks
//   FFT_IDX_W      : index width for the default transform size
//   bitrev()       : reverses the low 'width' bits of a value; bits above
//                    'width' come back as zero
// ---------------------------------------------------------------------------
package fft_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam int FFT_N_DEFAULT = 16;
   localparam int FFT_IDX_W     = $clog2(FFT_N_DEFAULT);

   // The loop is bounded by the full 32-bit argument so it unrolls to a
   // fixed wiring network; the runtime 'width' only selects which bits
   // take part. Callers pass a constant width, so this collapses to
   // plain rewiring.
   function automatic logic [31:0] bitrev(input logic [31:0] value,
                                          input int          width);
      logic [31:0] result;
      int          pos;
      result = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < width) begin
            pos = width - 1 - b;
            result[pos[4:0]] = value[b];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_word_select.sv
// ---------------------------------------------------------------------------
// fft_word_select
//
// Purely combinational N:1 word multiplexer over a packed frame buffer.
// The selected slot is either the index itself or its bit-reversed value,
// chosen at elaboration time by BIT_REV.
//
// Ports:
//   words  in  MSB*N   packed frame, slot k = words[MSB*k +: MSB]
//   index  in  IDX_W   output sequence number
//   word   out MSB     selected slot contents
// ---------------------------------------------------------------------------
module fft_word_select #(
   parameter  int N       = 16,
   parameter  int MSB     = 16,
   parameter  bit BIT_REV = 1'b0,
   localparam int IDX_W   = $clog2(N)
) (
   input  logic [MSB*N-1:0] words,
   input  logic [IDX_W-1:0] index,
   output logic [MSB-1:0]   word
);

   import fft_pkg::*;

   logic [IDX_W-1:0] slot;

   // Map the sequence number onto a buffer slot, then pick that word.
   // BIT_REV is a constant, so only one of the two slot paths survives.
   always_comb begin
      slot = index;
      if (BIT_REV) begin
         slot = IDX_W'(bitrev(32'(index), IDX_W));
      end
      word = words[MSB*slot +: MSB];
   end

endmodule

// File: rtl/fft_result_streamer.sv
// ---------------------------------------------------------------------------
// fft_result_streamer
//
// Sits at the output of the FFT core. Each rising edge of fft_finish
// snapshots the whole parallel result bus into a local frame buffer. The
// frame is then streamed one word per transfer over a valid/ready
// interface, tagged with its sequence number. Optionally the words come
// out in bit-reversed slot order.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   data_in      in   FFT result bus, word k = data_in[MSB*k +: MSB]
//   fft_finish   in   FFT completion flag, only its rising edge matters
//   out_data     out  current word
//   out_index    out  sequence number of the current word (0..N-1)
//   out_valid    out  out_data/out_index/out_last are valid
//   out_ready    in   consumer accepts the current word
//   out_last     out  current word is the final one of the frame
//   frame_done   out  one-cycle pulse after the final transfer
//   busy         out  a captured frame is not yet fully streamed
//   overrun      out  sticky, a frame was dropped while busy
//   clr_overrun  in   clears overrun (a simultaneous new overrun wins)
// ---------------------------------------------------------------------------
module fft_result_streamer #(
   parameter  int N       = 16,
   parameter  int MSB     = 16,
   parameter  bit BIT_REV = 1'b0,
   localparam int IDX_W   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [MSB*N-1:0] data_in,
   input  logic             fft_finish,
   output logic [MSB-1:0]   out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             frame_done,
   output logic             busy,
   output logic             overrun,
   input  logic             clr_overrun
);

   import fft_pkg::*;

   localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(N - 1);

   state_t           state;
   logic [MSB*N-1:0] frame_buf;
   logic             finish_hist;
   logic             finish_rise;
   logic             transfer;
   logic             final_transfer;
   logic             overrun_event;

   // Edge detection and handshake decode. finish_hist powers up high
   // through reset so a flag already asserted when reset drops is not
   // mistaken for a fresh completion.
   assign finish_rise    = fft_finish & ~finish_hist;
   assign transfer       = out_valid & out_ready;
   assign final_transfer = transfer & (out_index == LAST_INDEX);

   // A completion arriving mid-stream is dropped, unless it lands exactly
   // on the final transfer; then it simply becomes the next frame.
   assign overrun_event  = finish_rise & (state == ST_STREAM) & ~final_transfer;

   assign out_last = out_valid & (out_index == LAST_INDEX);

   // Streamer FSM. All status outputs are registered here; out_data and
   // out_last are decoded only from registered state, so out_ready never
   // reaches an output combinationally. The frame buffer is left out of
   // the reset branch because its contents are irrelevant until the next
   // capture overwrites them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         out_index   <= '0;
         out_valid   <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         finish_hist <= 1'b1;
      end else begin
         finish_hist <= fft_finish;
         frame_done  <= 1'b0;

         // Set has priority over clear so a drop is never lost.
         overrun <= (overrun & ~clr_overrun) | overrun_event;

         case (state)
            ST_IDLE: begin
               if (finish_rise) begin
                  frame_buf <= data_in;
                  out_index <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_STREAM;
               end
            end

            ST_STREAM: begin
               if (final_transfer) begin
                  frame_done <= 1'b1;
                  out_index  <= '0;
                  if (finish_rise) begin
                     // Back-to-back frame: keep valid high and restart.
                     frame_buf <= data_in;
                  end else begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end else if (transfer) begin
                  out_index <= out_index + 1'b1;
               end
            end

            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Word mux: slot chosen from the registered index, no added latency.
   fft_word_select #(
      .N       (N),
      .MSB     (MSB),
      .BIT_REV (BIT_REV)
   ) u_word_select (
      .words (frame_buf),
      .index (out_index),
      .word  (out_data)
   );

endmodule
